// File: rtl/adc_sample_source.sv
// adc_sample_source
//   Producer side of the ready/x sample stream feeding the LMS FIR path.
//   Raw unsigned ADC conversions are buffered in a small FIFO. Once every
//   SAMPLE_PERIOD clocks one entry is popped, and a leaky-integrator DC
//   estimate is subtracted from it. The result is presented on x_out as a
//   signed 16-bit sample, together with a one-cycle ready_out strobe.
//
// Ports
//   clk_in        in   system clock
//   rst_in        in   asynchronous active-low reset
//   enable_in     in   run pacing; low holds the tick counter at 0 and flushes the FIFO
//   adc_valid_in  in   one-cycle strobe qualifying adc_data_in
//   adc_data_in   in   raw unsigned conversion (ADC_W bits)
//   clear_in      in   one-cycle clear of the sticky flags
//   ready_out     out  one-cycle strobe, new x_out valid this cycle
//   x_out         out  signed DC-removed sample, held between strobes
//   dc_est_out    out  current DC estimate (acc >> DC_SHIFT)
//   underrun_out  out  sticky: a tick found the FIFO empty
//   overflow_out  out  sticky: a push was dropped because the FIFO was full
module adc_sample_source #(
   parameter int ADC_W         = 12,
   parameter int SAMPLE_PERIOD = 128,
   parameter int FIFO_DEPTH    = 4,
   parameter int DC_SHIFT      = 8,
   parameter int DC_INIT       = 1780
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             enable_in,
   input  logic             adc_valid_in,
   input  logic [ADC_W-1:0] adc_data_in,
   input  logic             clear_in,
   output logic             ready_out,
   output logic [15:0]      x_out,
   output logic [ADC_W-1:0] dc_est_out,
   output logic             underrun_out,
   output logic             overflow_out
);

   localparam int CNT_W = $clog2(SAMPLE_PERIOD);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int ACC_W = ADC_W + DC_SHIFT + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
   localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   LVL_ZERO = (PTR_W + 1)'(0);
   localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [ACC_W-1:0] ACC_INIT = ACC_W'(DC_INIT) << DC_SHIFT;

   typedef enum logic [1:0] {
      S_WAIT  = 2'd0,
      S_POP   = 2'd1,
      S_UNDER = 2'd2,
      S_EMIT  = 2'd3
   } state_t;

   // Raw minus estimate, both treated as unsigned, sign-extended to 16 bits.
   function automatic logic [15:0] centre(input logic [ADC_W-1:0] raw,
                                          input logic [ADC_W-1:0] est);
      logic [ADC_W:0] d;
      d = {1'b0, raw} - {1'b0, est};
      return 16'($signed(d));
   endfunction

   logic [CNT_W-1:0] count_r;
   logic             tick_s;

   logic [ADC_W-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   level_r;
   logic             empty_s;
   logic             full_s;
   logic             push_s;
   logic             pop_s;
   logic             drop_s;
   logic [ADC_W-1:0] head_s;

   state_t           state_r;
   state_t           state_nxt_s;

   logic [ACC_W-1:0] acc_r;
   logic [ADC_W-1:0] est_s;
   logic [15:0]      x_r;
   logic             ready_r;
   logic             underrun_r;
   logic             overflow_r;
   logic             under_set_s;

   // Tick, FIFO handshake and estimator decode.
   always_comb begin
      tick_s  = enable_in && (count_r == CNT_LAST);
      empty_s = (level_r == LVL_ZERO);
      full_s  = (level_r == LVL_FULL);
      head_s  = mem_r[rd_ptr_r];
      est_s   = ADC_W'(acc_r >> DC_SHIFT);
      // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
      pop_s   = (state_r == S_POP) && enable_in && !empty_s;
      push_s  = enable_in && adc_valid_in && (!full_s || pop_s);
      drop_s  = enable_in && adc_valid_in && full_s && !pop_s;
      under_set_s = (state_r == S_UNDER) && enable_in;
   end

   // Sample pacing counter, held at zero while disabled.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         count_r <= CNT_ZERO;
      end else if (!enable_in) begin
         count_r <= CNT_ZERO;
      end else if (count_r == CNT_LAST) begin
         count_r <= CNT_ZERO;
      end else begin
         count_r <= count_r + CNT_ONE;
      end
   end

   // Input FIFO storage, pointers and fill level; flushed while disabled.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         level_r  <= LVL_ZERO;
      end else if (!enable_in) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         level_r  <= LVL_ZERO;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= adc_data_in;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LVL_ONE;
            2'b01:   level_r <= level_r - LVL_ONE;
            default: level_r <= level_r;
         endcase
      end
   end

   // Sequencer state register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_r <= S_WAIT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Sequencer next state; disabling aborts a pending POP/UNDER back to WAIT.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_WAIT: begin
            if (tick_s) begin
               state_nxt_s = empty_s ? S_UNDER : S_POP;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_POP, S_UNDER: begin
            if (enable_in) begin
               state_nxt_s = S_EMIT;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_EMIT:  state_nxt_s = S_WAIT;
         default: state_nxt_s = S_WAIT;
      endcase
   end

   // Strobe register: high exactly while the sequencer sits in EMIT.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ready_r <= 1'b0;
      end else begin
         ready_r <= (state_nxt_s == S_EMIT);
      end
   end

   // DC estimator and output sample; both update only on a real pop.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         acc_r <= ACC_INIT;
         x_r   <= 16'd0;
      end else if (pop_s) begin
         // The estimate used here is the pre-update value.
         acc_r <= acc_r + ACC_W'(head_s) - ACC_W'(est_s);
         x_r   <= centre(head_s, est_s);
      end else begin
         acc_r <= acc_r;
         x_r   <= x_r;
      end
   end

   // Sticky flags; a set event in the same cycle beats clear_in.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         underrun_r <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         underrun_r <= under_set_s | (underrun_r & ~clear_in);
         overflow_r <= drop_s      | (overflow_r & ~clear_in);
      end
   end

   assign ready_out    = ready_r;
   assign x_out        = x_r;
   assign dc_est_out   = est_s;
   assign underrun_out = underrun_r;
   assign overflow_out = overflow_r;

endmodule

// File: tb/tb_adc_sample_source.sv
// Scoreboard bench for adc_sample_source (default parameters). Stimulus
// pushes hand-computed expected x values into a queue; the monitor pops one
// per ready_out strobe and also checks strobe spacing and x_out stability.
module tb_adc_sample_source;

   logic        clk_in;
   logic        rst_in;
   logic        enable_in;
   logic        adc_valid_in;
   logic [11:0] adc_data_in;
   logic        clear_in;
   logic        ready_out;
   logic [15:0] x_out;
   logic [11:0] dc_est_out;
   logic        underrun_out;
   logic        overflow_out;

   adc_sample_source dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .enable_in    (enable_in),
      .adc_valid_in (adc_valid_in),
      .adc_data_in  (adc_data_in),
      .clear_in     (clear_in),
      .ready_out    (ready_out),
      .x_out        (x_out),
      .dc_est_out   (dc_est_out),
      .underrun_out (underrun_out),
      .overflow_out (overflow_out)
   );

   int checks;
   int errors;
   int want_q[$];
   int strobe_cnt;
   int strobe_cyc;
   int cyc;

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk_in);
         cyc = cyc + 1;
      end
   end

   // Monitor: compares x_out at each strobe, checks period and stability.
   initial begin
      int prev_cyc;
      bit prev_valid;
      bit last_ready;
      logic [15:0] last_x;
      int xs;
      int w;
      strobe_cnt = 0;
      strobe_cyc = 0;
      prev_valid = 1'b0;
      last_ready = 1'b0;
      last_x     = 16'd0;
      prev_cyc   = 0;
      forever begin
         @(negedge clk_in);
         if (!rst_in) begin
            prev_valid = 1'b0;
            last_ready = 1'b0;
         end else begin
            if (ready_out) begin
               xs = $signed(x_out);
               checks = checks + 1;
               if (want_q.size() == 0) begin
                  errors = errors + 1;
                  $display("FAIL unexpected_strobe actual x=%0d required none", xs);
               end else begin
                  w = want_q.pop_front();
                  if (xs != w) begin
                     errors = errors + 1;
                     $display("FAIL x_out strobe %0d actual=%0d required=%0d", strobe_cnt, xs, w);
                  end
               end
               if (prev_valid) begin
                  checks = checks + 1;
                  if (cyc - prev_cyc != 128) begin
                     errors = errors + 1;
                     $display("FAIL strobe_period actual=%0d required=128", cyc - prev_cyc);
                  end
               end
               if (last_ready) begin
                  errors = errors + 1;
                  $display("FAIL ready_back_to_back actual=1 required=0");
               end
               prev_valid = 1'b1;
               prev_cyc   = cyc;
               strobe_cyc = cyc;
               strobe_cnt = strobe_cnt + 1;
            end else if (x_out !== last_x) begin
               errors = errors + 1;
               $display("FAIL x_out_stable actual=%0d required=%0d", x_out, last_x);
            end
            last_ready = ready_out;
         end
         last_x = x_out;
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks = checks + 1;
      if (act != req) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push(input int val);
      adc_valid_in = 1'b1;
      adc_data_in  = 12'(val);
      @(negedge clk_in);
      adc_valid_in = 1'b0;
      adc_data_in  = 12'd0;
   endtask

   task automatic wait_strobes(input string name, input int target, input int budget);
      int k;
      k = 0;
      while (strobe_cnt < target && k < budget) begin
         @(negedge clk_in);
         #1;
         k = k + 1;
      end
      chk({name, "_strobes"}, strobe_cnt, target);
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst_in       = 1'b0;
      enable_in    = 1'b0;
      adc_valid_in = 1'b0;
      clear_in     = 1'b0;
      want_q.delete();
      repeat (3) @(negedge clk_in);
      chk("rst_ready", int'(ready_out), 0);
      chk("rst_x", int'(x_out), 0);
      chk("rst_dc", int'(dc_est_out), 1780);
      chk("rst_underrun", int'(underrun_out), 0);
      chk("rst_overflow", int'(overflow_out), 0);
      rst_in = 1'b1;
      @(negedge clk_in);
   endtask

   initial begin
      int base;
      int ecyc;
      int burst[6];
      checks       = 0;
      errors       = 0;
      rst_in       = 1'b0;
      enable_in    = 1'b0;
      adc_valid_in = 1'b0;
      adc_data_in  = 12'd0;
      clear_in     = 1'b0;

      // 1) samples equal to DC_INIT: zero output, estimate unchanged
      do_reset();
      base = strobe_cnt;
      repeat (3) want_q.push_back(0);
      enable_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(1780);
         repeat (99) @(negedge clk_in);
      end
      wait_strobes("t1", base + 3, 60);
      chk("t1_dc", int'(dc_est_out), 1780);
      chk("t1_underrun", int'(underrun_out), 0);

      // 2) constant 2036: x decays 256,255,255,254; estimate rises to 1783
      do_reset();
      base = strobe_cnt;
      want_q.push_back(256);
      want_q.push_back(255);
      want_q.push_back(255);
      want_q.push_back(254);
      enable_in = 1'b1;
      repeat (4) push(2036);
      wait_strobes("t2", base + 4, 540);
      chk("t2_dc", int'(dc_est_out), 1783);
      chk("t2_overflow", int'(overflow_out), 0);
      chk("t2_underrun", int'(underrun_out), 0);

      // 3) no pushes: underrun strobes repeat x=0; clear then re-set
      do_reset();
      base = strobe_cnt;
      repeat (3) want_q.push_back(0);
      enable_in = 1'b1;
      wait_strobes("t3a", base + 2, 300);
      chk("t3_underrun_set", int'(underrun_out), 1);
      clear_in = 1'b1;
      @(negedge clk_in);
      clear_in = 1'b0;
      #1;
      chk("t3_underrun_clr", int'(underrun_out), 0);
      wait_strobes("t3b", base + 3, 140);
      chk("t3_underrun_again", int'(underrun_out), 1);

      // 4) burst of 6 into depth-4 FIFO: 4 kept in order, then underrun repeat
      do_reset();
      base = strobe_cnt;
      burst = '{1790, 1800, 1810, 1820, 1830, 1840};
      want_q.push_back(10);
      want_q.push_back(20);
      want_q.push_back(30);
      want_q.push_back(40);
      want_q.push_back(40);
      enable_in = 1'b1;
      for (int i = 0; i < 6; i++) push(burst[i]);
      #1;
      chk("t4_overflow", int'(overflow_out), 1);
      wait_strobes("t4", base + 5, 660);
      chk("t4_underrun", int'(underrun_out), 1);
      chk("t4_dc", int'(dc_est_out), 1780);

      // 5) push during POP with FIFO full is accepted without overflow
      do_reset();
      base = strobe_cnt;
      want_q.push_back(0);
      want_q.push_back(-10);
      want_q.push_back(-19);
      want_q.push_back(-29);
      want_q.push_back(-39);
      want_q.push_back(-49);
      enable_in = 1'b1;
      push(1780);
      wait_strobes("t5a", base + 1, 140);
      push(1770);
      push(1760);
      push(1750);
      push(1740);
      repeat (123) @(negedge clk_in);
      push(1730);
      wait_strobes("t5b", base + 6, 660);
      chk("t5_overflow", int'(overflow_out), 0);
      chk("t5_dc", int'(dc_est_out), 1779);

      // 6a) reset asserted during EMIT clears outputs immediately
      do_reset();
      base = strobe_cnt;
      want_q.push_back(256);
      enable_in = 1'b1;
      push(2036);
      wait_strobes("t6a", base + 1, 140);
      rst_in = 1'b0;
      #1;
      chk("t6_rst_ready", int'(ready_out), 0);
      chk("t6_rst_x", int'(x_out), 0);
      chk("t6_rst_dc", int'(dc_est_out), 1780);

      // 6b) enable low flushes FIFO; next strobe 129 clocks after re-enable
      do_reset();
      base = strobe_cnt;
      enable_in = 1'b1;
      push(2036);
      push(2036);
      repeat (48) @(negedge clk_in);
      enable_in = 1'b0;
      repeat (20) @(negedge clk_in);
      chk("t6_no_strobe", strobe_cnt, base);
      want_q.push_back(0);
      enable_in = 1'b1;
      ecyc = cyc;
      wait_strobes("t6b", base + 1, 140);
      chk("t6_strobe_delay", strobe_cyc - ecyc, 129);
      chk("t6_underrun", int'(underrun_out), 1);
      chk("t6_dc", int'(dc_est_out), 1780);

      chk("queue_drained", want_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
